// File: rtl/bus_arbiter_2to1.sv
// Two-requester round-robin arbiter with a burst limit and a registered output stage.
// Requesters hand over beats with Req/Ack; the consumer takes Out_Data with Out_Valid/Out_Ready.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | channel free, no owner
//   OWN0  | requester 0 owns the channel (Sel=0)
//   OWN1  | requester 1 owns the channel (Sel=1)
module bus_arbiter_2to1 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req0,
    input  logic [WIDTH-1:0] Data0,
    output logic             Ack0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Data1,
    output logic             Ack1,
    output logic             Sel,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             w_can_load;
    logic             w_ack0;
    logic             w_ack1;
    logic             w_ack;
    logic [WIDTH-1:0] w_mux_data;

    // Outputs are forced inactive while reset is held, whatever the state register holds.
    assign w_can_load = !r_out_valid || Out_Ready;
    assign w_ack0     = !reset && (r_state == OWN0) && Req0 && w_can_load;
    assign w_ack1     = !reset && (r_state == OWN1) && Req1 && w_can_load;
    assign w_ack      = w_ack0 || w_ack1;
    assign w_mux_data = (r_state == OWN1) ? Data1 : Data0;

    assign Ack0      = w_ack0;
    assign Ack1      = w_ack1;
    assign Sel       = !reset && (r_state == OWN1);
    assign Busy      = !reset && (r_state != IDLE);
    assign Out_Data  = r_out_data;
    assign Out_Valid = r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ack) begin
                r_out_data  <= w_mux_data;
                r_out_valid <= 1'b1;
            end else if (Out_Ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (Req0 || Req1) begin
                    w_cnt_nxt = '0;
                    // On a tie the requester that did not own the channel last wins.
                    if (Req0 && (!Req1 || r_last)) begin
                        w_state_nxt = OWN0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = OWN1;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            OWN0: begin
                if (!Req0) begin
                    w_cnt_nxt = '0;
                    if (Req1) begin
                        w_state_nxt = OWN1;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_ack0) begin
                    if (r_cnt == CNT_MAX) begin
                        w_cnt_nxt = '0;
                        if (Req1) begin
                            w_state_nxt = OWN1;
                            w_last_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            OWN1: begin
                if (!Req1) begin
                    w_cnt_nxt = '0;
                    if (Req0) begin
                        w_state_nxt = OWN0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_ack1) begin
                    if (r_cnt == CNT_MAX) begin
                        w_cnt_nxt = '0;
                        if (Req0) begin
                            w_state_nxt = OWN0;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed vectors for bus_arbiter_2to1: inputs are driven on the falling edge and
// every output is compared 2 time units later, before the next rising edge.
module tb_bus_arbiter_2to1;

    logic        clk;
    logic        reset;
    logic        Req0;
    logic [31:0] Data0;
    logic        Ack0;
    logic        Req1;
    logic [31:0] Data1;
    logic        Ack1;
    logic        Sel;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        r0;
        logic [31:0] d0;
        logic        r1;
        logic [31:0] d1;
        logic        rdy;
        logic        a0;
        logic        a1;
        logic        sel;
        logic        busy;
        logic        ov;
        logic [31:0] od;
    } vec_t;

    vec_t tbl[$];

    bus_arbiter_2to1 #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Req0      (Req0),
        .Data0     (Data0),
        .Ack0      (Ack0),
        .Req1      (Req1),
        .Data1     (Data1),
        .Ack1      (Ack1),
        .Sel       (Sel),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic r0, input logic [31:0] d0,
                                input logic r1, input logic [31:0] d1, input logic rdy,
                                input logic a0, input logic a1, input logic sel,
                                input logic busy, input logic ov, input logic [31:0] od);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.rdy = rdy;
        v.a0 = a0; v.a1 = a1; v.sel = sel; v.busy = busy; v.ov = ov; v.od = od;
        return v;
    endfunction

    task automatic run(input string tag, input vec_t v);
        logic [36:0] act;
        logic [36:0] exp;
        @(negedge clk);
        reset     = v.rst;
        Req0      = v.r0;
        Data0     = v.d0;
        Req1      = v.r1;
        Data1     = v.d1;
        Out_Ready = v.rdy;
        #2;
        act = {Ack0, Ack1, Sel, Busy, Out_Valid, Out_Data};
        exp = {v.a0, v.a1, v.sel, v.busy, v.ov, v.od};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got ack0,ack1,sel,busy,valid=%b%b%b%b%b data=%h, want %b%b%b%b%b data=%h",
                     tag, act[36], act[35], act[34], act[33], act[32], act[31:0],
                     exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1; Req0 = 1'b0; Data0 = '0; Req1 = 1'b0; Data1 = '0; Out_Ready = 1'b1;

        // reset, then a single requester-0 beat
        tbl.push_back(mk(1,0,32'h0,0,32'h0,1,              0,0,0,0,0,32'h0));
        tbl.push_back(mk(1,0,32'h0,0,32'h0,1,              0,0,0,0,0,32'h0));
        tbl.push_back(mk(0,1,32'h11111111,0,32'h0,1,       0,0,0,0,0,32'h0));
        tbl.push_back(mk(0,1,32'h11111111,0,32'h0,1,       1,0,0,1,0,32'h0));
        tbl.push_back(mk(0,0,32'h11111111,0,32'h0,1,       0,0,0,1,1,32'h11111111));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,0,0,0,0,32'h11111111));
        // reset, then both requesting: 4 beats each, no bubble, requester 0 first
        tbl.push_back(mk(1,0,32'h0,0,32'h0,1,              0,0,0,0,0,32'h11111111));
        tbl.push_back(mk(0,1,32'hA0000001,1,32'hB0000001,1, 0,0,0,0,0,32'h0));
        tbl.push_back(mk(0,1,32'hA0000001,1,32'hB0000001,1, 1,0,0,1,0,32'h0));
        tbl.push_back(mk(0,1,32'hA0000002,1,32'hB0000001,1, 1,0,0,1,1,32'hA0000001));
        tbl.push_back(mk(0,1,32'hA0000003,1,32'hB0000001,1, 1,0,0,1,1,32'hA0000002));
        tbl.push_back(mk(0,1,32'hA0000004,1,32'hB0000001,1, 1,0,0,1,1,32'hA0000003));
        tbl.push_back(mk(0,1,32'hA0000005,1,32'hB0000001,1, 0,1,1,1,1,32'hA0000004));
        tbl.push_back(mk(0,1,32'hA0000005,1,32'hB0000002,1, 0,1,1,1,1,32'hB0000001));
        tbl.push_back(mk(0,1,32'hA0000005,1,32'hB0000003,1, 0,1,1,1,1,32'hB0000002));
        tbl.push_back(mk(0,1,32'hA0000005,1,32'hB0000004,1, 0,1,1,1,1,32'hB0000003));
        tbl.push_back(mk(0,1,32'hA0000005,1,32'hB0000005,1, 1,0,0,1,1,32'hB0000004));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,0,0,1,1,32'hA0000005));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,0,0,0,0,32'hA0000005));
        // consumer stall holds the beat and blocks Ack
        tbl.push_back(mk(0,1,32'hC0000001,0,32'h0,1,       0,0,0,0,0,32'hA0000005));
        tbl.push_back(mk(0,1,32'hC0000001,0,32'h0,0,       1,0,0,1,0,32'hA0000005));
        tbl.push_back(mk(0,1,32'hC0000002,0,32'h0,0,       0,0,0,1,1,32'hC0000001));
        tbl.push_back(mk(0,1,32'hC0000002,0,32'h0,0,       0,0,0,1,1,32'hC0000001));
        tbl.push_back(mk(0,1,32'hC0000002,0,32'h0,1,       1,0,0,1,1,32'hC0000001));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,0,0,1,1,32'hC0000002));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              0,0,0,0,0,32'hC0000002));
        // owner 0 drops mid-burst: one bubble cycle, then requester 1
        tbl.push_back(mk(0,1,32'hD0000001,0,32'h0,1,       0,0,0,0,0,32'hC0000002));
        tbl.push_back(mk(0,1,32'hD0000001,1,32'hE0000001,1, 1,0,0,1,0,32'hC0000002));
        tbl.push_back(mk(0,0,32'h0,1,32'hE0000001,1,       0,0,0,1,1,32'hD0000001));
        tbl.push_back(mk(0,0,32'h0,1,32'hE0000001,1,       0,1,1,1,0,32'hD0000001));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,0,1,1,1,32'hE0000001));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,0,0,0,0,32'hE0000001));

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d", i), tbl[i]);

        // requester 1 alone for 10 beats: the burst counter wraps without a release
        run("r1_grant", mk(0,0,32'h0,1,32'hF0000001,1, 0,0,0,0,0,32'hE0000001));
        for (int i = 0; i < 10; i++)
            run($sformatf("r1_beat%0d", i),
                mk(0,0,32'h0,1,32'hF0000001 + 32'(i),1, 0,1,1,1,
                   (i == 0) ? 1'b0 : 1'b1,
                   (i == 0) ? 32'hE0000001 : 32'hF0000000 + 32'(i)));
        run("r1_drop", mk(0,0,32'h0,0,32'h0,1, 0,0,1,1,1,32'hF000000A));

        // reset in the middle of an OWN1 burst
        run("rst_grant", mk(0,0,32'h0,1,32'h12340001,1, 0,0,0,0,0,32'hF000000A));
        run("rst_beat0", mk(0,0,32'h0,1,32'h12340001,1, 0,1,1,1,0,32'hF000000A));
        run("rst_beat1", mk(0,0,32'h0,1,32'h12340002,1, 0,1,1,1,1,32'h12340001));
        run("rst_hold",  mk(1,1,32'h55550001,1,32'h12340003,1, 0,0,0,0,1,32'h12340002));
        run("rst_idle",  mk(0,1,32'h55550001,1,32'h12340003,1, 0,0,0,0,0,32'h0));
        run("rst_tie",   mk(0,1,32'h55550001,1,32'h12340003,1, 1,0,0,1,0,32'h0));
        run("rst_out",   mk(0,0,32'h0,0,32'h0,1, 0,0,0,1,1,32'h55550001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2to1.md
# bus_arbiter_2to1

Round-robin arbiter that shares a single 32-bit output channel between two requesters. It drives the select line of the team's 32-bit 2:1 mux and owns the registered output stage behind it. It sits between two producers, for example a PC/ALU result path and a load path, and one consumer using a valid/ready handshake. A burst counter bounds how long one requester can hold the channel while the other is waiting.

## Interface
Parameters:
- WIDTH, 32, data width of both inputs and the output.
- MAX_BURST, 4, maximum consecutive beats per grant while the other requester is waiting (≥1).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Req0  input  1  requester 0 has a beat to send.
- Data0  input  WIDTH  requester 0 beat data.
- Ack0  output  1  requester 0 beat accepted this cycle (combinational).
- Req1  input  1  requester 1 has a beat to send.
- Data1  input  WIDTH  requester 1 beat data.
- Ack1  output  1  requester 1 beat accepted this cycle (combinational).
- Sel  output  1  mux select: 1 means requester 1 owns the channel.
- Out_Data  output  WIDTH  registered output beat.
- Out_Valid  output  1  Out_Data holds an unconsumed beat.
- Out_Ready  input  1  consumer accepts Out_Data this cycle.
- Busy  output  1  channel currently owned (state ≠ IDLE).

## Operation
- State machine has three states: IDLE, OWN0, OWN1.
- Registers: state, Last (last owner), burst count cnt (0..MAX_BURST-1), Out_Data, Out_Valid.
- Sel is 1 only in OWN1. Busy is 1 in OWN0 and OWN1.
- can_load = !Out_Valid | Out_Ready.
- Ack:
  - Ack0 = (state==OWN0) & Req0 & can_load.
  - Ack1 = (state==OWN1) & Req1 & can_load.
  - Ack is never asserted in IDLE.
- Ack beat:
  - Out_Data loads the muxed data (Data1 if Sel, else Data0).
  - Out_Valid is set to 1.
- Without an Ack, Out_Valid clears on Out_Ready. Otherwise Out_Data and Out_Valid hold.
- Transitions from IDLE:
  - Only Req0 → OWN0.
  - Only Req1 → OWN1.
  - Both → owner is !Last.
  - On entry: Last takes the new owner and cnt is cleared to 0.
- Transitions from OWNx:
  - Reqx==0 → release. Go to OWN(other) if the other Req is high, else IDLE. cnt is cleared to 0.
  - Ackx with cnt==MAX_BURST-1 and other Req high → OWN(other). cnt is cleared to 0 and Last is updated.
  - Ackx with cnt==MAX_BURST-1 and other Req low → stay. cnt wraps to 0.
  - Ackx otherwise → cnt+1.
  - No Ack (stalled by the consumer) → no state or cnt change.
- Requester rules:
  - Datax must be held stable while Reqx=1 and Ackx=0.
  - Reqx may drop at any time. No beat is lost, because no Ack was given.
- Reset sets state=IDLE, Last=1 (so requester 0 wins the first tie), cnt=0, Out_Data=0 and Out_Valid=0. The outputs during reset are Sel=0, Ack0=Ack1=0 and Busy=0.
- Reset asserted mid-burst discards any pending Out_Data beat. The next grant follows the first-tie rule.

## Timing
- Arbitration latency: Req rising while in IDLE gives Ack at the earliest on the next cycle.
- Out_Valid and Out_Data update on the clock edge that consumes an Ack, i.e. one cycle after Ack.
- Throughput is 1 beat per cycle with Out_Ready held at 1.
- Handover on a burst limit costs zero bubble cycles: the new owner's Ack comes in the next cycle.
- Handover on a Req drop costs one bubble cycle: the drop cycle itself carries no Ack.
- Simultaneous Out_Ready and Ack loads the new beat. Out_Valid stays 1.
- Sel changes only on a clock edge. It is stable for the whole cycle in which Ack is asserted.

## Test plan
- Reset → Out_Valid=0, Out_Data=0, Sel=0, Busy=0, no Acks. Then Req0=1, Data0=0x11111111 → Ack0 on cycle 2, Out_Data=0x11111111 with Out_Valid=1 on cycle 3.
- Req0 and Req1 both held high, Out_Ready=1, MAX_BURST=4 → four Ack0 beats, then four Ack1 beats, alternating with no bubble. The first grant goes to requester 0.
- Requester 1 only, Req1 high for 10 beats → Sel=1 throughout, 10 consecutive Ack1 beats, cnt wraps and there is no release.
- Out_Ready=0 with a beat held in Out_Valid → Ack0 stays 0 and Out_Data is stable. Out_Ready=1 in the same cycle as a new Ack → the new value is loaded and Out_Valid stays 1.
- Owner 0 drops Req0 mid-burst while Req1 is high → one cycle with no Ack, then OWN1. Ack1 follows in the next cycle with Sel=1.
- Reset asserted during an OWN1 burst → the next cycle is in IDLE with Out_Valid=0. With both Reqs high afterwards, requester 0 is granted first.
